// File: rtl/dmem_pkg.sv
// dmem_pkg: shared op encodings, class masks and FSM states for the MEM-stage access sequencer
package dmem_pkg;
  localparam logic [7:0] OP_LB  = 8'h01;
  localparam logic [7:0] OP_LBU = 8'h02;
  localparam logic [7:0] OP_LH  = 8'h04;
  localparam logic [7:0] OP_LHU = 8'h08;
  localparam logic [7:0] OP_LW  = 8'h10;
  localparam logic [7:0] OP_SB  = 8'h20;
  localparam logic [7:0] OP_SH  = 8'h40;
  localparam logic [7:0] OP_SW  = 8'h80;
  localparam logic [7:0] LOAD_MASK     = 8'h1F;
  localparam logic [7:0] SUBSTORE_MASK = 8'h60;
  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;
endpackage

// File: rtl/dmem_op_decode.sv
// dmem_op_decode: classifies a one-hot memory op and flags alignment faults
// Ports: op (one-hot op), low_addr (byte offset) -> is_valid, is_load, is_sub_store, is_sw, is_misaligned
// Macro: DMEM_ALIGN_CHECK_EN enables the alignment fault; otherwise is_misaligned is 0.
module dmem_op_decode
  import dmem_pkg::*;
(
  input  logic [7:0] op,
  input  logic [1:0] low_addr,
  output logic       is_valid,
  output logic       is_load,
  output logic       is_sub_store,
  output logic       is_sw,
  output logic       is_misaligned
);
  // exactly one bit set: nonzero and clearing the lowest set bit leaves nothing
  assign is_valid     = (op != 8'h00) && ((op & (op - 8'd1)) == 8'h00);
  assign is_load      = is_valid && ((op & LOAD_MASK) != 8'h00);
  assign is_sub_store = is_valid && ((op & SUBSTORE_MASK) != 8'h00);
  assign is_sw        = op == OP_SW;
`ifdef DMEM_ALIGN_CHECK_EN
  assign is_misaligned = is_valid &&
    ((((op & (OP_LH | OP_LHU | OP_SH)) != 8'h00) && low_addr[0]) ||
     (((op & (OP_LW | OP_SW)) != 8'h00) && (low_addr != 2'b00)));
`else
  logic w_unused;
  assign w_unused      = ^low_addr;
  assign is_misaligned = 1'b0;
`endif
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one held load/store into dmem read, write or read-modify-write
// Ports: clk/rst_n; req_* held request; stall/done/load_data/misalign to pipeline;
//        dmem_* to synchronous data memory; lane_* to/from byte-lane merge/extend unit.
// Macro: DMEM_ALIGN_CHECK_EN turns misaligned half/word accesses into faults.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DMEM_AW = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [7:0]         req_op,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               stall,
  output logic               done,
  output logic [31:0]        load_data,
  output logic               misalign,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  output logic [7:0]         lane_op,
  output logic [1:0]         lane_low_addr,
  output logic [31:0]        lane_rf_data,
  output logic [31:0]        lane_dmem_data,
  input  logic [31:0]        lane_odata
);
  state_t      r_state, w_next;
  logic [31:0] r_wbuf, r_load_data;
  logic        r_misalign;
  logic        w_is_valid, w_is_load, w_is_sub_store, w_is_sw, w_is_mis, w_accept, w_in_rd;
  dmem_op_decode u_dec (
    .op            (req_op),
    .low_addr      (req_addr[1:0]),
    .is_valid      (w_is_valid),
    .is_load       (w_is_load),
    .is_sub_store  (w_is_sub_store),
    .is_sw         (w_is_sw),
    .is_misaligned (w_is_mis)
  );
  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_in_rd  = r_state == ST_RD;
  // request fields are held while stalled, so the live decode stays valid past accept
  always_comb begin
    w_next = ST_IDLE;
    w_next = (r_state == ST_IDLE) ? (!req_valid ? ST_IDLE :
                                     (!w_is_valid || w_is_mis) ? ST_DONE :
                                     w_is_sw ? ST_WR : ST_RD) :
             (r_state == ST_RD)   ? (w_is_load ? ST_DONE : ST_WR) :
             (r_state == ST_WR)   ? ST_DONE : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wbuf      <= '0;
      r_load_data <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_next == ST_WR) r_wbuf <= req_wdata;
      else if (w_in_rd && w_is_sub_store) r_wbuf <= lane_odata;
      if (w_in_rd && w_is_load) r_load_data <= lane_odata;
      if (w_accept) r_misalign <= w_is_mis;
    end
  end
  assign done           = r_state == ST_DONE;
  assign misalign       = done && r_misalign;
  assign stall          = req_valid && !done;
  assign load_data      = r_load_data;
  assign dmem_we        = r_state == ST_WR;
  assign dmem_wdata     = r_wbuf;
  assign dmem_addr      = req_addr[DMEM_AW+1:2];
  assign lane_op        = req_op;
  assign lane_low_addr  = req_addr[1:0];
  assign lane_rf_data   = req_wdata;
  assign lane_dmem_data = dmem_rdata;
  logic w_unused;
  assign w_unused = ^{req_addr[31:DMEM_AW+2], w_is_load & 1'b0};
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and randomized checks of dmem_access_ctrl with a lane unit and synchronous RAM
module tb_dmem_access_ctrl;
  import dmem_pkg::*;
  localparam int AW = 11;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0;
  logic [7:0] req_op = 8'h00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic stall, done, misalign, dmem_we;
  logic [31:0] load_data, dmem_wdata, dmem_rdata, lane_rf_data, lane_dmem_data, lane_odata;
  logic [AW-1:0] dmem_addr;
  logic [7:0] lane_op;
  logic [1:0] lane_low_addr;
  int errors = 0, checks = 0;
  dmem_access_ctrl #(.DMEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .done(done), .load_data(load_data), .misalign(misalign),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .lane_op(lane_op), .lane_low_addr(lane_low_addr), .lane_rf_data(lane_rf_data),
    .lane_dmem_data(lane_dmem_data), .lane_odata(lane_odata)
  );
  logic [31:0] ram [0:2047];
  logic pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [31:0] pl_d = '0;
  always @(posedge clk) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (dmem_we) ram[dmem_addr] <= dmem_wdata;
    dmem_rdata <= ram[dmem_addr];
  end
  logic [7:0] l_b;
  logic [15:0] l_h;
  always_comb begin
    l_b = lane_low_addr == 2'd0 ? lane_dmem_data[7:0] : lane_low_addr == 2'd1 ? lane_dmem_data[15:8] :
          lane_low_addr == 2'd2 ? lane_dmem_data[23:16] : lane_dmem_data[31:24];
    l_h = lane_low_addr[1] ? lane_dmem_data[31:16] : lane_dmem_data[15:0];
    lane_odata = lane_rf_data;
    case (lane_op)
      OP_LB:  lane_odata = {{24{l_b[7]}}, l_b};
      OP_LBU: lane_odata = {24'h0, l_b};
      OP_LH:  lane_odata = {{16{l_h[15]}}, l_h};
      OP_LHU: lane_odata = {16'h0, l_h};
      OP_LW:  lane_odata = lane_dmem_data;
      OP_SB:  case (lane_low_addr)
                2'd0: lane_odata = {lane_dmem_data[31:8], lane_rf_data[7:0]};
                2'd1: lane_odata = {lane_dmem_data[31:16], lane_rf_data[7:0], lane_dmem_data[7:0]};
                2'd2: lane_odata = {lane_dmem_data[31:24], lane_rf_data[7:0], lane_dmem_data[15:0]};
                default: lane_odata = {lane_rf_data[7:0], lane_dmem_data[23:0]};
              endcase
      OP_SH:  lane_odata = lane_low_addr[1] ? {lane_rf_data[15:0], lane_dmem_data[15:0]}
                                            : {lane_dmem_data[31:16], lane_rf_data[15:0]};
      default: lane_odata = lane_rf_data;
    endcase
  end
  logic [31:0] mref [0:2047];
  logic [31:0] exp_ld = '0;
  function automatic logic [31:0] mload(input logic [7:0] op, input logic [31:0] w, input logic [1:0] lo);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (op)
      OP_LB:   return (b >= 32'h80) ? b - 32'h100 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32'h8000) ? h - 32'h10000 : h;
      OP_LHU:  return h;
      default: return w;
    endcase
  endfunction
  function automatic logic [31:0] mstore(input logic [7:0] op, input logic [31:0] w, input logic [31:0] wd, input logic [1:0] lo);
    case (op)
      OP_SB:   return (w & ~(32'hFF << (8 * lo))) | ((wd & 32'hFF) << (8 * lo));
      OP_SH:   return (w & ~(32'hFFFF << (16 * lo[1]))) | ((wd & 32'hFFFF) << (16 * lo[1]));
      default: return wd;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output int dc, output int wc, output int wcyc, output logic mis, output logic sbad);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    dc = -1; wc = 0; wcyc = -1; mis = 1'b0; sbad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("dmem_addr", 32'(dmem_addr), 32'(a[AW+1:2]));
        check("lane_op", 32'(lane_op), 32'(op));
      end
      if (dmem_we) begin wc++; wcyc = c; end
      if (done) begin
        dc = c; mis = misalign;
        if (stall !== 1'b0) sbad = 1'b1;
        break;
      end
      if (stall !== 1'b1) sbad = 1'b1;
      @(posedge clk); #1;
    end
  endtask
  task automatic do_op(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd);
    int sz, edc, ewc, ewcyc, dc, wc, wcyc;
    logic valid, fault, mis, sbad;
    logic [AW-1:0] wi;
    wi = a[AW+1:2];
    valid = $countones(op) == 1;
    sz = (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : (op == OP_LW || op == OP_SW) ? 4 : 1;
`ifdef DMEM_ALIGN_CHECK_EN
    fault = valid && (int'(a) % sz != 0);
`else
    fault = 1'b0;
`endif
    edc = (!valid || fault) ? 1 : (op == OP_SB || op == OP_SH) ? 3 : 2;
    ewc = (valid && !fault && op >= OP_SB) ? 1 : 0;
    ewcyc = ewc == 0 ? -1 : (op == OP_SW) ? 1 : 2;
    if (valid && !fault && op <= OP_LW) exp_ld = mload(op, mref[wi], a[1:0]);
    if (valid && !fault && op >= OP_SB) mref[wi] = mstore(op, mref[wi], wd, a[1:0]);
    run_op(op, a, wd, dc, wc, wcyc, mis, sbad);
    check({tag, " done_cycle"}, 32'(dc), 32'(edc));
    check({tag, " we_count"}, 32'(wc), 32'(ewc));
    check({tag, " we_cycle"}, 32'(wcyc), 32'(ewcyc));
    check({tag, " misalign"}, 32'(mis), 32'(fault));
    check({tag, " stall"}, 32'(sbad), 32'h0);
    check({tag, " load_data"}, load_data, exp_ld);
    check({tag, " mem_word"}, ram[wi], mref[wi]);
  endtask
  initial begin
    logic [7:0] ops [0:7];
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      pl_en = 1'b1; pl_a = AW'(i); pl_d = (i == 4) ? 32'h8899AABB : $urandom;
      mref[i] = pl_d;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;
    @(negedge clk);
    check("reset done", 32'(done), 32'h0);
    check("reset we", 32'(dmem_we), 32'h0);
    check("reset misalign", 32'(misalign), 32'h0);
    check("reset load_data", load_data, 32'h0);
    check("reset stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op("lb 0x11", OP_LB, 32'h11, 32'h0);
    check("lb value", load_data, 32'hFFFFFFAA);
    do_op("sb 0x13", OP_SB, 32'h13, 32'h55);
    check("sb13 word", ram[4], 32'h5599AABB);
    do_op("sb 0x10", OP_SB, 32'h10, 32'h55);
    check("sb10 word", ram[4], 32'h5599AA55);
    do_op("sw 0x14", OP_SW, 32'h14, 32'hDEADBEEF);
    do_op("lhu 0x16", OP_LHU, 32'h16, 32'h0);
    check("lhu value", load_data, 32'h0000DEAD);
    do_op("sw restore", OP_SW, 32'h10, 32'h8899AABB);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h10; req_wdata = 32'h1234;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst done", 32'(done), 32'h0);
    check("rst we", 32'(dmem_we), 32'h0);
    check("rst misalign", 32'(misalign), 32'h0);
    check("rst load_data", load_data, 32'h0);
    exp_ld = 32'h0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst word kept", ram[4], 32'h8899AABB);
    do_op("lw after rst", OP_LW, 32'h10, 32'h0);
    check("lw after rst value", load_data, 32'h8899AABB);
    do_op("lb prime", OP_LB, 32'h11, 32'h0);
    do_op("lw 0x12", OP_LW, 32'h12, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    check("lw 0x12 value", load_data, 32'hFFFFFFAA);
`else
    check("lw 0x12 value", load_data, 32'h8899AABB);
`endif
    do_op("op 0x03", 8'h03, 32'h10, 32'h0);
    do_op("op 0x00", 8'h00, 32'h14, 32'h0);
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      do_op("rand", k < 8 ? ops[k] : (k == 8 ? 8'h81 : 8'h00), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage access sequencer for the static 5-stage pipeline. It sits between the EX/MEM pipeline register and the synchronous data memory, upstream of the byte-lane merge/extend unit. It turns one held load/store request into the right dmem read, write or read-modify-write sequence. It stalls the pipeline until the op completes, then returns the registered, aligned load result.

## Interface
- `DMEM_AW`, default 11: dmem word-address width.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, 1 bit: MEM stage holds a memory op.
- `req_op` input, 8 bits: one-hot op. Bit 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw.
- `req_addr` input, 32 bits: byte address.
- `req_wdata` input, 32 bits: store data from the register file.
- `stall` output, 1 bit: hold the pipeline.
- `done` output, 1 bit: one-cycle completion pulse.
- `load_data` output, 32 bits: registered load result.
- `misalign` output, 1 bit: alignment fault; valid with `done`.
- `dmem_addr` output, DMEM_AW bits: equals `req_addr[DMEM_AW+1:2]`.
- `dmem_we` output, 1 bit: dmem write enable.
- `dmem_wdata` output, 32 bits: write word.
- `dmem_rdata` input, 32 bits: read word, valid one cycle after the address.
- `lane_op` output, 8 bits: to the lane unit; equals `req_op`.
- `lane_low_addr` output, 2 bits: equals `req_addr[1:0]`.
- `lane_rf_data` output, 32 bits: equals `req_wdata`.
- `lane_dmem_data` output, 32 bits: equals `dmem_rdata`.
- `lane_odata` input, 32 bits: merged or extended word from the lane unit.

## Operation
- States: IDLE, RD, WR, DONE.
- From IDLE with `req_valid=1`, the next state depends on the op class:
  - Load (bits 0–4): go to RD.
  - sb or sh: go to RD.
  - sw: go to WR; capture `req_wdata` into `wbuf`.
  - Non-one-hot or zero `req_op`: go to DONE. No memory access.
- RD:
  - For a load, capture `lane_odata` into `load_data`, then go to DONE.
  - For sb/sh, capture `lane_odata` (the merged word) into `wbuf`, then go to WR.
- WR: `dmem_we=1` and `dmem_wdata=wbuf`, then go to DONE.
- DONE: `done=1`, then go to IDLE.
- `stall = req_valid & ~done`. It is combinational.
- Request fields must be held while `stall=1`. After accept, the FSM ignores `req_valid`. An accepted op always runs to DONE.
- `dmem_we` is decoded from the state register only. It is never high outside WR.
- `load_data` changes only on load completion. It holds its value across stores, faults and invalid ops.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `done`, `dmem_we` and `misalign` go to 0.
  - `load_data` and `wbuf` go to 0.
  - Reset before the WR edge aborts a sub-word store. Memory is unchanged.

## Timing
Cycle 0 is the IDLE accept cycle.
- Load: read issued in cycle 0; capture at the end of cycle 1; `done` in cycle 2; occupancy 3 cycles.
- sw: write in cycle 1; `done` in cycle 2.
- sb/sh: read in cycle 0; merge captured at the end of cycle 1; write in cycle 2; `done` in cycle 3.
- Invalid op or alignment fault: `done` in cycle 1.
- Back-to-back ops: the next op is accepted in the cycle after DONE, so there is no gap beyond the DONE cycle.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - These are faults: lh, lhu or sh with `addr[0]=1`; lw or sw with `addr[1:0]≠0`.
  - On a fault: IDLE goes to DONE, no dmem access, `misalign=1` alongside `done`, `load_data` unchanged.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - `misalign` is tied to 0.
  - All addresses are accessed. Lane selection follows the lane unit's low-address rules.

## Structure
- Shared package `dmem_pkg` holds:
  - the op one-hot constants `OP_LB` through `OP_SW`;
  - the state enum;
  - the class masks `LOAD_MASK` and `SUBSTORE_MASK`.
- One natural sub-module, `dmem_op_decode`. It is combinational and produces `is_load`, `is_sub_store`, `is_sw`, `is_valid` and `is_misaligned`.

## Test plan
The bench uses the real lane unit and a synchronous RAM. Word 0x10 preloaded with 0x8899AABB.
- lb at 0x11 → `stall` high in cycles 0–1; `done` in cycle 2; `load_data`=0xFFFFFFAA; `dmem_we` never high.
- sb at 0x13 with wdata 0x55 → single `dmem_we` pulse in cycle 2; word becomes 0x5599AABB; `done` in cycle 3. Repeat at 0x10 → 0x5599AA55.
- sw at 0x14 with 0xDEADBEEF, then immediately lhu at 0x16 → write in cycle 1; `done` in cycle 2; lhu accepted in cycle 3; `load_data`=0x0000DEAD.
- sh at 0x10 with `rst_n` pulsed low during RD → outputs 0 immediately; no write; word stays 0x8899AABB; next lw returns 0x8899AABB.
- lw at 0x12 → with the macro: `done` and `misalign` in cycle 1, no access, `load_data` unchanged. Without the macro: `done` in cycle 2, `load_data`=0x8899AABB.
- `req_op`=0x03 → `done` in cycle 1; no dmem access; `load_data` unchanged.
